// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI burst master
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  // Mode number is {cpol, cpha}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_NUM_CS     = 4;

  function automatic logic mode_cpol(input spi_mode_e m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_fifo.sv
// rtl/spi_fifo.sv - show-ahead synchronous FIFO with registered full/empty flags
module spi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Flags are computed from the next count so they are exact in the same cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// rtl/spi_master_mc.sv - SPI burst master with TX/RX FIFOs, four modes and chip-select decode
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int NUM_CS     = DEF_NUM_CS
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         start,
  output logic                                         done,
  output logic                                         busy,
  input  logic                                         in_wr_en,
  input  logic [DATA_W-1:0]                            in_din,
  output logic                                         in_full,
  input  logic                                         out_rd_en,
  output logic [DATA_W-1:0]                            out_dout,
  output logic                                         out_empty,
  input  logic                                         cpol,
  input  logic                                         cpha,
  input  logic [$clog2((NUM_CS > 1) ? NUM_CS : 2)-1:0] cs_sel,
  input  logic [7:0]                                   clk_div,
  output logic                                         sclk,
  output logic                                         mosi,
  input  logic                                         miso,
  output logic [NUM_CS-1:0]                            cs_n,
  output logic                                         rx_overflow
);
  localparam int CS_W = $clog2((NUM_CS > 1) ? NUM_CS : 2);
  localparam int EW   = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  spi_state_e        state;
  spi_state_e        state_nxt;
  spi_mode_e         mode_q;
  logic [CS_W-1:0]   cs_q;
  logic [7:0]        div_q;
  logic [7:0]        half_cnt;
  logic [EW-1:0]     edge_cnt;
  logic              skip_q;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              sclk_q;
  logic              ovf_q;

  logic [DATA_W-1:0] tx_dout;
  logic              tx_empty;
  logic              tx_rd_en;
  logic [DATA_W-1:0] rx_din;
  logic              rx_full;
  logic              rx_wr_en;

  logic              tick;
  logic              word_end;
  logic              cpha_q;
  logic              sample_edge;
  logic              cs_active;

  spi_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (in_wr_en),
    .din   (in_din),
    .full  (in_full),
    .rd_en (tx_rd_en),
    .dout  (tx_dout),
    .empty (tx_empty)
  );

  spi_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (rx_wr_en),
    .din   (rx_din),
    .full  (rx_full),
    .rd_en (out_rd_en),
    .dout  (out_dout),
    .empty (out_empty)
  );

  assign cpha_q      = mode_cpha(mode_q);
  assign tick        = (half_cnt == div_q);
  assign word_end    = (state == SHIFT) && tick && (edge_cnt == LAST_EDGE);
  // Even edge counts are leading edges; cpha picks which parity samples miso
  assign sample_edge = (edge_cnt[0] == cpha_q);
  assign cs_active   = ((state == SETUP) || (state == SHIFT) || (state == HOLD)) && !skip_q;

  // With cpha=1 the final sample lands on the word-end edge itself
  assign rx_din = cpha_q ? {rx_sh[DATA_W-2:0], miso} : rx_sh;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_rd_en  = 1'b0;
    rx_wr_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          tx_rd_en  = !tx_empty;
        end
      end
      SETUP: begin
        if (skip_q)    state_nxt = DONE;
        else if (tick) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (word_end) begin
          tx_rd_en = !tx_empty;
          rx_wr_en = !rx_full;
          if (tx_empty) state_nxt = HOLD;
        end
      end
      HOLD:    if (tick) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q   <= MODE0;
      cs_q     <= '0;
      div_q    <= '0;
      half_cnt <= '0;
      edge_cnt <= '0;
      skip_q   <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      sclk_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sclk_q   <= cpol;
          half_cnt <= '0;
          edge_cnt <= '0;
          if (start) begin
            mode_q <= spi_mode_e'({cpol, cpha});
            cs_q   <= cs_sel;
            div_q  <= clk_div;
            skip_q <= tx_empty;
            ovf_q  <= 1'b0;
            tx_sh  <= tx_empty ? '0 : tx_dout;
          end
        end
        SETUP: begin
          sclk_q   <= mode_cpol(mode_q);
          half_cnt <= tick ? 8'd0 : half_cnt + 8'd1;
        end
        SHIFT: begin
          if (tick) begin
            half_cnt <= '0;
            sclk_q   <= ~sclk_q;
            if (sample_edge) rx_sh <= {rx_sh[DATA_W-2:0], miso};
            if (word_end) begin
              edge_cnt <= '0;
              tx_sh    <= tx_empty ? '0 : tx_dout;
              if (rx_full) ovf_q <= 1'b1;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
              // cpha=1 already shows bit 0, so its first leading edge does not shift
              if (!sample_edge && !(cpha_q && (edge_cnt == '0)))
                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        HOLD:    half_cnt <= tick ? 8'd0 : half_cnt + 8'd1;
        default: half_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    cs_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      cs_n[i] = !(cs_active && (cs_q == CS_W'(i)));
    end
  end

  assign sclk        = sclk_q;
  assign mosi        = tx_sh[DATA_W-1];
  assign done        = (state == DONE);
  assign busy        = (state != IDLE);
  assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// tb/tb_spi_master_mc.sv - directed self-checking bench for spi_master_mc
module tb_spi_master_mc;

  logic       clock;
  logic       reset;
  logic       start;
  logic       done;
  logic       busy;
  logic       in_wr_en;
  logic [7:0] in_din;
  logic       in_full;
  logic       out_rd_en;
  logic [7:0] out_dout;
  logic       out_empty;
  logic       cpol;
  logic       cpha;
  logic [1:0] cs_sel;
  logic [7:0] clk_div;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [3:0] cs_n;
  logic       rx_overflow;

  int total = 0;
  int bad   = 0;

  logic       loop_en;
  logic [7:0] sl_tx;
  logic [7:0] sl_rx;
  logic       sl_first;
  logic       sl_sclk;
  logic       mosi_d;
  logic       lead;

  spi_master_mc dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .in_wr_en    (in_wr_en),
    .in_din      (in_din),
    .in_full     (in_full),
    .out_rd_en   (out_rd_en),
    .out_dout    (out_dout),
    .out_empty   (out_empty),
    .cpol        (cpol),
    .cpha        (cpha),
    .cs_sel      (cs_sel),
    .clk_div     (clk_div),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso),
    .cs_n        (cs_n),
    .rx_overflow (rx_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign miso = loop_en ? mosi : sl_tx[7];

  // SPI slave: returns 0xC3 and shifts in mosi using values held before each sclk edge
  always @(negedge clock or sclk) begin
    if (sclk !== sl_sclk) begin
      if (cs_n != 4'hF) begin
        lead = (sclk != cpol);
        if (lead ^ cpha) begin
          sl_rx = {sl_rx[6:0], mosi_d};
        end else if (cpha && sl_first) begin
          sl_first = 1'b0;
        end else begin
          sl_tx = {sl_tx[6:0], 1'b0};
        end
      end
      sl_sclk = sclk;
    end else begin
      mosi_d = mosi;
      if (cs_n == 4'hF) begin
        sl_tx    = 8'hC3;
        sl_first = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] w);
    in_din   = w;
    in_wr_en = 1'b1;
    tick();
    in_wr_en = 1'b0;
  endtask

  task automatic pop();
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  // Starts a burst and watches it cycle by cycle until done or a cycle budget expires
  task automatic run_burst(input int sel, input int restart_at, output int lo, output int tg,
                           output int badcs, output int rel, output bit got_done);
    logic       prev_sclk;
    logic       prev_lo;
    logic [3:0] exp_lo;
    lo = 0; tg = 0; badcs = 0; rel = 0; got_done = 1'b0;
    exp_lo    = 4'hF & ~(4'b0001 << sel);
    prev_sclk = sclk;
    prev_lo   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 3000 && !got_done; n++) begin
      start = (n == restart_at);
      if (cs_n === exp_lo) lo++;
      else if (cs_n !== 4'hF) badcs++;
      if (prev_lo && cs_n === 4'hF) rel++;
      prev_lo = (cs_n === exp_lo);
      if (sclk !== prev_sclk) tg++;
      prev_sclk = sclk;
      if (done === 1'b1) got_done = 1'b1;
      else tick();
    end
    start = 1'b0;
  endtask

  int lo, tg, badcs, rel;
  bit got;
  logic [1:0] m;

  initial begin
    reset = 1'b0; start = 1'b0; in_wr_en = 1'b0; in_din = 8'h00; out_rd_en = 1'b0;
    cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0; clk_div = 8'd1; loop_en = 1'b1;
    tick(); tick();

    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out_empty", out_empty, 1'b1);
    chk("rst_in_full", in_full, 1'b0);
    chk("rst_ovf", rx_overflow, 1'b0);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_cs_n", cs_n, 4'hF);
    reset = 1'b1;
    tick();

    // Mode 0 loopback, 4-clock sclk period
    write_word(8'hA5);
    run_burst(0, -1, lo, tg, badcs, rel, got);
    chk("m0_done", got, 1'b1);
    chk("m0_cs_cycles", lo, 36);
    chk("m0_sclk_edges", tg, 16);
    chk("m0_other_cs", badcs, 0);
    chk("m0_cs_release", rel, 1);
    tick();
    chk("m0_busy_after", busy, 1'b0);
    chk("m0_rx", out_dout, 8'hA5);
    pop();
    chk("m0_rx_empty", out_empty, 1'b1);

    // Modes 1..3 against the slave model
    loop_en = 1'b0;
    for (int k = 1; k < 4; k++) begin
      m = 2'(k);
      cpol = m[1];
      cpha = m[0];
      tick();
      chk($sformatf("mode%0d_idle_pre", k), sclk, cpol);
      write_word(8'h3C);
      run_burst(0, -1, lo, tg, badcs, rel, got);
      chk($sformatf("mode%0d_done", k), got, 1'b1);
      chk($sformatf("mode%0d_cs_cycles", k), lo, 36);
      chk($sformatf("mode%0d_idle_post", k), sclk, cpol);
      chk($sformatf("mode%0d_slave_rx", k), sl_rx, 8'h3C);
      tick();
      chk($sformatf("mode%0d_rx", k), out_dout, 8'hC3);
      pop();
    end
    loop_en = 1'b1;
    cpol = 1'b0; cpha = 1'b0;
    tick();

    // Three-word continuous frame on cs_n[2]
    cs_sel = 2'd2; clk_div = 8'd0;
    write_word(8'h01); write_word(8'h02); write_word(8'h03);
    run_burst(2, -1, lo, tg, badcs, rel, got);
    chk("multi_done", got, 1'b1);
    chk("multi_cs_cycles", lo, 50);
    chk("multi_sclk_edges", tg, 48);
    chk("multi_other_cs", badcs, 0);
    chk("multi_cs_release", rel, 1);
    tick();
    chk("multi_rx0", out_dout, 8'h01); pop();
    chk("multi_rx1", out_dout, 8'h02); pop();
    chk("multi_rx2", out_dout, 8'h03); pop();
    chk("multi_rx_empty", out_empty, 1'b1);

    // Fill RX, then overflow it
    cs_sel = 2'd0;
    for (int i = 0; i < 16; i++) write_word(8'h10 + 8'(i));
    chk("tx_full", in_full, 1'b1);
    write_word(8'hFF);
    run_burst(0, -1, lo, tg, badcs, rel, got);
    chk("fill_done", got, 1'b1);
    chk("fill_cs_cycles", lo, 258);
    tick();
    chk("fill_ovf", rx_overflow, 1'b0);
    chk("fill_in_full", in_full, 1'b0);
    write_word(8'hEE);
    run_burst(0, -1, lo, tg, badcs, rel, got);
    chk("ovf_done", got, 1'b1);
    tick();
    chk("ovf_flag", rx_overflow, 1'b1);

    // Empty-TX burst: no chip select, done two cycles after start, clears overflow
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_busy", busy, 1'b1);
    chk("empty_done_early", done, 1'b0);
    chk("empty_cs_n1", cs_n, 4'hF);
    chk("empty_ovf_clr", rx_overflow, 1'b0);
    tick();
    chk("empty_done", done, 1'b1);
    chk("empty_cs_n2", cs_n, 4'hF);
    tick();
    chk("empty_done_end", done, 1'b0);
    chk("empty_busy_end", busy, 1'b0);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_rx%0d", i), out_dout, 8'h10 + 8'(i));
      pop();
    end
    chk("ovf_rx_empty", out_empty, 1'b1);

    // Start while busy is ignored
    cs_sel = 2'd1; clk_div = 8'd3;
    write_word(8'h5A);
    run_burst(1, 20, lo, tg, badcs, rel, got);
    chk("rst_ign_done", got, 1'b1);
    chk("rst_ign_cs_cycles", lo, 72);
    chk("rst_ign_sclk_edges", tg, 16);
    tick();
    chk("rst_ign_busy", busy, 1'b0);
    tick();
    chk("rst_ign_no_done", done, 1'b0);
    chk("rst_ign_rx", out_dout, 8'h5A);
    pop();

    // Reset mid-word with a second word still buffered
    cs_sel = 2'd0; clk_div = 8'd1;
    write_word(8'h55); write_word(8'h66);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_cs_low", cs_n, 4'hE);
    reset = 1'b0;
    #1;
    chk("mid_rst_cs_n", cs_n, 4'hF);
    chk("mid_rst_sclk", sclk, 1'b0);
    chk("mid_rst_mosi", mosi, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    reset = 1'b1;
    tick();
    chk("post_rst_out_empty", out_empty, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_in_full", in_full, 1'b0);
    write_word(8'h96);
    run_burst(0, -1, lo, tg, badcs, rel, got);
    chk("post_rst_done", got, 1'b1);
    chk("post_rst_cs_cycles", lo, 36);
    tick();
    chk("post_rst_rx", out_dout, 8'h96);
    pop();
    chk("post_rst_rx_empty", out_empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
